// File: rtl/bsg_rr_mux_arb_pkg.sv
// Shared helpers for the round-robin one-hot mux arbiter: pointer sizing,
// one-hot decode and the rotate used by the priority scan (els_p <= 32).
package bsg_rr_mux_arb_pkg;

  localparam int max_els_lp = 32;

  function automatic int ptr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic logic [31:0] onehot_to_index(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < max_els_lp; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits of x left by amt, where 0 <= amt <= n.
  function automatic logic [31:0] rotl(input logic [31:0] x, input int amt, input int n);
    logic [63:0] m;
    logic [63:0] xx;
    m  = (64'd1 << n) - 64'd1;
    xx = {32'd0, x} & m;
    xx = ((xx << amt) | (xx >> (n - amt))) & m;
    return xx[31:0];
  endfunction

endpackage

// File: rtl/bsg_rr_mux_one_hot_arb_if.sv
// Requester/consumer bundle for bsg_rr_mux_one_hot_arb. lock_i exists only
// when BSG_RR_MUX_ARB_LOCK_EN is defined.
interface bsg_rr_mux_one_hot_arb_if #(
  parameter int width_p = 9,
  parameter int els_p   = 3
);
  logic [els_p-1:0]         v_i;
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         ready_o;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic [els_p-1:0]         grant_o;
  logic                     ready_i;
`ifdef BSG_RR_MUX_ARB_LOCK_EN
  logic [els_p-1:0]         lock_i;

  modport slave  (input  v_i, data_i, ready_i, lock_i, output ready_o, v_o, data_o, grant_o);
  modport master (output v_i, data_i, ready_i, lock_i, input  ready_o, v_o, data_o, grant_o);
`else
  modport slave  (input  v_i, data_i, ready_i, output ready_o, v_o, data_o, grant_o);
  modport master (output v_i, data_i, ready_i, input  ready_o, v_o, data_o, grant_o);
`endif
endinterface

// File: rtl/bsg_mux_one_hot.sv
// AND-OR one-hot mux: req k's word sits at data_i[k*width_p +: width_p].
module bsg_mux_one_hot #(
  parameter int width_p = 1,
  parameter int els_p   = 1
) (
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic [width_p-1:0]       data_o
);
  logic [width_p-1:0] masked [els_p];

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_mask
      assign masked[gi] = data_i[gi*width_p +: width_p] & {width_p{sel_one_hot_i[gi]}};
    end
  endgenerate

  always_comb begin
    data_o = '0;
    for (int i = 0; i < els_p; i++) data_o = data_o | masked[i];
  end
endmodule

// File: rtl/bsg_rr_mux_arb_prio.sv
// Rotated fixed-priority pick: first valid requester at or above ptr_i+1
// (mod els_p) wins; no valid requester gives an all-zero select.
module bsg_rr_mux_arb_prio
  import bsg_rr_mux_arb_pkg::*;
#(
  parameter int els_p   = 3,
  parameter int ptr_w_p = ptr_width(els_p)
) (
  input  logic [els_p-1:0]   v_i,
  input  logic [ptr_w_p-1:0] ptr_i,
  output logic [els_p-1:0]   sel_one_hot_o
);
  int               start;
  logic [els_p-1:0] rot_v;
  logic [els_p-1:0] pick;

  always_comb begin
    start = (int'(ptr_i) >= els_p - 1) ? 0 : int'(ptr_i) + 1;
    // Bring the scan start to bit 0, take the lowest set bit, rotate back.
    rot_v = els_p'(rotl(32'(v_i), (start == 0) ? 0 : els_p - start, els_p));
    pick  = rot_v & (~rot_v + els_p'(1));
    sel_one_hot_o = els_p'(rotl(32'(pick), start, els_p));
  end
endmodule

// File: rtl/bsg_rr_mux_one_hot_arb.sv
// Round-robin arbiter driving a shared one-hot mux into a one-entry output
// buffer. Define BSG_RR_MUX_ARB_LOCK_EN to add packet locking via lock_i.
module bsg_rr_mux_one_hot_arb
  import bsg_rr_mux_arb_pkg::*;
#(
  parameter int width_p = 9,
  parameter int els_p   = 3
) (
  input logic                       clk_i,
  input logic                       reset_n_i,
  bsg_rr_mux_one_hot_arb_if.slave   bus
);
  localparam int ptr_w_lp = ptr_width(els_p);

  logic                v_q, v_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [els_p-1:0]    grant_q, grant_d;
  logic [ptr_w_lp-1:0] ptr_q, ptr_d;
  logic                load_en;
  logic [els_p-1:0]    arb_v;
  logic [els_p-1:0]    sel;
  logic [width_p-1:0]  mux_data;

`ifdef BSG_RR_MUX_ARB_LOCK_EN
  logic [els_p-1:0] lock_q, lock_d;

  // A held lock narrows arbitration to the locked requester only.
  assign arb_v = (|lock_q) ? (bus.v_i & lock_q) : bus.v_i;

  always_comb begin
    lock_d = lock_q;
    if (load_en && (|sel)) lock_d = (|(sel & bus.lock_i)) ? sel : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lock_q <= '0;
    else            lock_q <= lock_d;
  end
`else
  assign arb_v = bus.v_i;
`endif

  bsg_rr_mux_arb_prio #(
    .els_p   (els_p),
    .ptr_w_p (ptr_w_lp)
  ) u_prio (
    .v_i           (arb_v),
    .ptr_i         (ptr_q),
    .sel_one_hot_o (sel)
  );

  bsg_mux_one_hot #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_mux (
    .data_i        (bus.data_i),
    .sel_one_hot_i (sel),
    .data_o        (mux_data)
  );

  assign load_en     = ~v_q | bus.ready_i;
  assign bus.ready_o = sel & {els_p{load_en}};
  assign bus.v_o     = v_q;
  assign bus.data_o  = data_q;
  assign bus.grant_o = grant_q;

  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (|sel) begin
        v_d     = 1'b1;
        data_d  = mux_data;
        grant_d = sel;
        ptr_d   = ptr_w_lp'(onehot_to_index(32'(sel)));
      end else begin
        v_d = 1'b0;
      end
    end
  end

  // Pointer starts at the top requester so requester 0 wins first after reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= ptr_w_lp'(els_p - 1);
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_bsg_rr_mux_one_hot_arb.sv
// Directed plus random bench for bsg_rr_mux_one_hot_arb with a cycle model and
// an output scoreboard. Lock steps run when BSG_RR_MUX_ARB_LOCK_EN is defined.
module tb_bsg_rr_mux_one_hot_arb;
  localparam int W = 9;
  localparam int N = 3;

  typedef struct packed {
    logic [W-1:0] d;
    logic [N-1:0] g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bsg_rr_mux_one_hot_arb_if #(.width_p(W), .els_p(N)) bus ();

  bsg_rr_mux_one_hot_arb #(.width_p(W), .els_p(N)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic         m_v;
  logic [W-1:0] m_data;
  logic [N-1:0] m_grant;
  int           m_ptr;
  logic [N-1:0] m_lock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int ptr,
                                              input logic [N-1:0] lock);
    logic [N-1:0] veff;
    logic [N-1:0] r;
    veff = (lock != '0) ? (v & lock) : v;
    r = '0;
    for (int s = 1; s <= N; s++) begin
      int k;
      k = (ptr + s) % N;
      if (veff[k] && r == '0) r[k] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_v = 1'b0; m_data = '0; m_grant = '0; m_ptr = N - 1; m_lock = '0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check model vs DUT, advance model, return after posedge.
  task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic [N-1:0] lck,
                       input logic [N*W-1:0] d);
    logic [N-1:0] sel;
    logic         load;
    logic [W-1:0] md;
    exp_t         e;
    @(negedge clk);
    bus.v_i = v; bus.ready_i = rdy; bus.data_i = d;
`ifdef BSG_RR_MUX_ARB_LOCK_EN
    bus.lock_i = lck;
`endif
    #1;
    chk("v_o", 32'(bus.v_o), 32'(m_v));
    chk("data_o", 32'(bus.data_o), 32'(m_data));
    chk("grant_o", 32'(bus.grant_o), 32'(m_grant));
    load = !m_v || rdy;
    sel  = model_pick(v, m_ptr, m_lock);
    chk("ready_o", 32'(bus.ready_o), 32'(load ? sel : '0));
    if (bus.v_o && rdy) begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", 32'(bus.data_o), 32'(e.d));
        chk("sb_grant", 32'(bus.grant_o), 32'(e.g));
      end
    end
    if (load) begin
      if (|sel) begin
        md = '0;
        for (int k = 0; k < N; k++) if (sel[k]) md = d[k*W +: W];
        sb.push_back('{d: md, g: sel});
        m_v = 1'b1; m_data = md; m_grant = sel;
        for (int k = 0; k < N; k++) if (sel[k]) m_ptr = k;
`ifdef BSG_RR_MUX_ARB_LOCK_EN
        m_lock = (|(sel & lck)) ? sel : '0;
`endif
      end else begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [N*W-1:0] dd;
  logic [N-1:0]   g2 [4];
  logic [W-1:0]   d2 [4];

  initial begin
    dd = {9'h1AA, 9'h155, 9'h0FF};
    g2 = '{3'b001, 3'b010, 3'b100, 3'b001};
    d2 = '{9'h0FF, 9'h155, 9'h1AA, 9'h0FF};
    bus.v_i = '0; bus.ready_i = 1'b0; bus.data_i = '0;
`ifdef BSG_RR_MUX_ARB_LOCK_EN
    bus.lock_i = '0;
`endif
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_v", 32'(bus.v_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    rst_n = 1'b1;

    // All requesters valid, consumer always ready: rotate 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      cycle(3'b111, 1'b1, '0, dd);
      chk("t2_grant", 32'(bus.grant_o), 32'(g2[i]));
      chk("t2_data", 32'(bus.data_o), 32'(d2[i]));
    end

    // Backpressure holds the buffer, then the next winner loads with no bubble.
    repeat (4) begin
      cycle(3'b111, 1'b0, '0, dd);
      chk("t3_hold_grant", 32'(bus.grant_o), 32'd1);
      chk("t3_hold_data", 32'(bus.data_o), 32'h0FF);
    end
    cycle(3'b111, 1'b1, '0, dd);
    chk("t3_next_grant", 32'(bus.grant_o), 32'd2);
    chk("t3_next_v", 32'(bus.v_o), 32'd1);

    // Sole requester wins every cycle across pointer wrap.
    repeat (5) begin
      cycle(3'b100, 1'b1, '0, dd);
      chk("t4_grant", 32'(bus.grant_o), 32'd4);
      chk("t4_data", 32'(bus.data_o), 32'h1AA);
    end

    // No requests while draining: valid drops, word holds.
    cycle(3'b000, 1'b1, '0, dd);
    chk("t5_v", 32'(bus.v_o), 32'd0);
    chk("t5_data", 32'(bus.data_o), 32'h1AA);

    repeat (60) begin
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), '0, 27'($urandom));
    end

    // Async reset while a word is buffered.
    cycle(3'b111, 1'b0, '0, dd);
    @(negedge clk);
    bus.v_i = '0; bus.ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_v", 32'(bus.v_o), 32'd0);
    chk("rstmid_data", 32'(bus.data_o), 32'd0);
    chk("rstmid_grant", 32'(bus.grant_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(3'b111, 1'b1, '0, dd);
    chk("rstmid_first", 32'(bus.grant_o), 32'd1);

`ifdef BSG_RR_MUX_ARB_LOCK_EN
    // Requester 1 locks for three words, tail word releases, then requester 2.
    cycle(3'b001, 1'b1, '0, dd);
    repeat (3) begin
      cycle(3'b111, 1'b1, 3'b010, dd);
      chk("t6_lock_grant", 32'(bus.grant_o), 32'd2);
    end
    cycle(3'b111, 1'b1, 3'b000, dd);
    chk("t6_tail_grant", 32'(bus.grant_o), 32'd2);
    cycle(3'b111, 1'b1, 3'b000, dd);
    chk("t6_after_grant", 32'(bus.grant_o), 32'd4);
`endif

    cycle(3'b000, 1'b1, '0, dd);
    cycle(3'b000, 1'b1, '0, dd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
